// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter onto a single memory bus.
// One transaction in flight; data has priority except right after a data transaction.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        src_data_q, src_data_d;
  logic        last_data_q, last_data_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        sel_data, sel_inst;

  // Inst only beats data when both request and data was served last.
  always_comb begin
    sel_data = (state_q == IDLE) && data_req
               && !(inst_req && last_data_q);
    sel_inst = (state_q == IDLE) && inst_req && !sel_data;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    src_data_d   = src_data_q;
    last_data_d  = last_data_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (sel_data) begin
          state_d     = WAIT_GNT;
          addr_d      = data_addr;
          wr_d        = data_wr;
          wstrb_d     = data_wr ? data_wstrb : 4'b0000;
          wdata_d     = data_wdata;
          src_data_d  = 1'b1;
          last_data_d = 1'b1;
        end else if (sel_inst) begin
          state_d     = WAIT_GNT;
          addr_d      = inst_addr;
          wr_d        = 1'b0;
          wstrb_d     = 4'b0000;
          wdata_d     = 32'h0;
          src_data_d  = 1'b0;
          last_data_d = 1'b0;
        end
      end
      WAIT_GNT: begin
        if (mem_gnt) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (src_data_q) begin
            data_ok_d = 1'b1;
            if (!wr_q) data_rdata_d = mem_rdata;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      wr_q         <= 1'b0;
      wstrb_q      <= 4'b0000;
      wdata_q      <= 32'h0;
      src_data_q   <= 1'b0;
      last_data_q  <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      src_data_q   <= src_data_d;
      last_data_q  <= last_data_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_addr_ok = sel_inst && !reset;
  assign data_addr_ok = sel_data && !reset;
  assign inst_data_ok = inst_ok_q;
  assign data_data_ok = data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign mem_req      = (state_q == WAIT_GNT);
  assign mem_wr       = wr_q;
  assign mem_addr     = addr_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_wdata    = wdata_q;

endmodule
